// File: rtl/robertson_mult_ctrl.sv
// Robertson shift-add multiplier controller: owns M, {A,Q} and the step counter.
// Optional `ifdef MULT_ABORT_EN adds an abort input that cancels a running multiply.
module robertson_mult_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MULT_ABORT_EN
    input  logic               abort,
`endif
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_q, r_m;
    logic [CW-1:0]    r_cnt;
    logic             r_sgn;
    logic             w_load, w_step, w_last, w_abort;
    logic [WIDTH:0]   w_ext_a, w_ext_m, w_sum;

`ifdef MULT_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_next = S_RUN;
                w_load = 1'b1;
            end
            // abort wins over the final step; the partial {A,Q} is left untouched
            S_RUN: if (w_abort) begin
                w_next = S_IDLE;
            end else begin
                w_step = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ext_a = r_sgn ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
        w_ext_m = r_sgn ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
        w_sum   = w_ext_a;
        // the signed multiplier's MSB carries negative weight, hence subtract on the last step
        if (r_q[0]) begin
            if (w_last && r_sgn) w_sum = w_ext_a - w_ext_m;
            else                 w_sum = w_ext_a + w_ext_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
            r_sgn <= 1'b0;
        end else if (w_load) begin
            r_a   <= '0;
            r_q   <= multiplier;
            r_m   <= multiplicand;
            r_cnt <= '0;
            r_sgn <= sgn;
        end else if (w_step) begin
            r_a   <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = {r_a, r_q};
endmodule

// File: tb/tb_robertson_mult_ctrl.sv
// Scoreboard bench for robertson_mult_ctrl (WIDTH=16): directed vectors, queue-based done monitor.
module tb_robertson_mult_ctrl;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           sgn = 1'b0;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           busy, done;
    logic [2*W-1:0] product;
`ifdef MULT_ABORT_EN
    logic           abort = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    robertson_mult_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef MULT_ABORT_EN
        .abort        (abort),
`endif
        .start        (start),
        .sgn          (sgn),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: product=%h with no outstanding request", product);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                if (product !== e) begin
                    fails++;
                    $display("FAIL product: got %h expected %h", product, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // pulse start for one cycle; returns just after the accepting edge
    task automatic issue(input logic s, input logic [W-1:0] m, input logic [W-1:0] q);
        @(posedge clk); #1;
        sgn = s; mcand = m; mplier = q; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mcand = ~m; mplier = ~q; sgn = ~s;  // latched copies must be used
    endtask

    // count busy cycles until done, bounded
    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
    endtask

    task automatic mult(input string name, input logic s, input logic [W-1:0] m,
                        input logic [W-1:0] q, input logic [2*W-1:0] e);
        int  nb;
        bit  seen;
        exp_q.push_back(e);
        issue(s, m, q);
        wait_done(nb, seen);
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_busy_cycles"}, 64'(nb), 64'(W));
    endtask

    initial begin
        int  nb;
        bit  seen;
        #12;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        rst_n = 1'b1;

        mult("s_3x5",        1'b1, 16'd3,     16'd5,     32'h0000000F);
        mult("s_m3x5",       1'b1, 16'hFFFD,  16'd5,     32'hFFFFFFF1);
        mult("s_5xm3",       1'b1, 16'd5,     16'hFFFD,  32'hFFFFFFF1);
        mult("s_min_min",    1'b1, 16'h8000,  16'h8000,  32'h40000000);
        mult("s_max_min",    1'b1, 16'h7FFF,  16'h8000,  32'hC0008000);
        mult("s_m1_m1",      1'b1, 16'hFFFF,  16'hFFFF,  32'h00000001);
        mult("s_m1_min",     1'b1, 16'hFFFF,  16'h8000,  32'h00008000);
        mult("u_ffff_ffff",  1'b0, 16'hFFFF,  16'hFFFF,  32'hFFFE0001);
        mult("u_zero",       1'b0, 16'h0000,  16'h1234,  32'h00000000);
        mult("u_8000x2",     1'b0, 16'h8000,  16'h0002,  32'h00010000);

        // starts during RUN and in the DONE cycle are dropped
        exp_q.push_back(32'h0000000F);
        issue(1'b1, 16'd3, 16'd5);
        repeat (4) @(posedge clk);
        #1; sgn = 1'b0; mcand = 16'd7; mplier = 16'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(nb, seen);
        check("ignore_done_seen", 64'(seen), 64'd1);
        start = 1'b1; mcand = 16'd11; mplier = 16'd13;
        @(posedge clk); #1; start = 1'b0;
        repeat (25) @(negedge clk);
        check("ignore_busy", 64'(busy), 64'd0);
        check("ignore_product_held", 64'(product), 64'h0000000F);

        // reset mid-RUN clears everything and suppresses done
        issue(1'b1, 16'd1234, 16'd77);
        repeat (7) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        check("rst_run_busy", 64'(busy), 64'd0);
        check("rst_run_done", 64'(done), 64'd0);
        check("rst_run_product", 64'(product), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("rst_run_idle", 64'(busy), 64'd0);
        mult("after_rst", 1'b1, 16'hFFF9, 16'd6, 32'hFFFFFFD6);

`ifdef MULT_ABORT_EN
        issue(1'b1, 16'd1234, 16'd77);
        repeat (7) @(posedge clk);
        #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        repeat (25) @(negedge clk);
        check("abort_idle", 64'(busy), 64'd0);
        mult("after_abort", 1'b0, 16'd300, 16'd200, 32'd60000);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
